// File: rtl/i2c_target.sv
// i2c_target: I2C target with an 8-bit register pointer and a simple
// register-file style host interface.
//   clk, rst        clock, asynchronous active-high reset
//   scl, sda        I2C bus (sda is open drain, driven only to 0 or z)
//   busy            high from START until STOP
//   wr_valid/wr_reg/wr_data   one-clk write strobe with index and byte
//   rd_req/rd_reg   one-clk read request with index
//   rd_data         read byte, valid by the second clk after rd_req
// Bus protocol: [addr,W] ptr data... writes from ptr upward;
// [addr,R] data... reads from ptr upward. Pointer survives transactions.
module i2c_target #(
   parameter logic [6:0] ADDRESS = 7'h42,
   parameter int         FILTER  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl,
   inout  wire        sda,
   output logic       busy,
   output logic       wr_valid,
   output logic [7:0] wr_reg,
   output logic [7:0] wr_data,
   output logic       rd_req,
   output logic [7:0] rd_reg,
   input  logic [7:0] rd_data
);

   localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
   } state_t;

   // index 0 = scl, index 1 = sda
   logic [1:0]    raw, s1, s2, filt, filt_q;
   logic [CW-1:0] fcnt [2];

   state_t     state;
   logic       sda_oe;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] ptr;
   logic       rw;
   logic       ack_bit;
   logic [1:0] ld_cnt;

   assign sda = sda_oe ? 1'b0 : 1'bz;
   assign raw = {sda, scl};

   // Synchronizer plus glitch filter: a new level is accepted only after
   // FILTER consecutive samples disagree with the current filtered level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1      <= 2'b11;
         s2      <= 2'b11;
         filt    <= 2'b11;
         filt_q  <= 2'b11;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         s1     <= raw;
         s2     <= s1;
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == CW'(FILTER - 1)) begin
               filt[i] <= s2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   logic scl_f, sda_f, scl_p, sda_p;
   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_f     = filt[0];
   assign sda_f     = filt[1];
   assign scl_p     = filt_q[0];
   assign sda_p     = filt_q[1];
   assign scl_rise  = scl_f & ~scl_p;
   assign scl_fall  = ~scl_f & scl_p;
   // SCL must be high on both samples so an SCL/SDA change landing on the
   // same clk is never mistaken for a START or STOP.
   assign start_det = scl_f & scl_p & sda_p & ~sda_f;
   assign stop_det  = scl_f & scl_p & ~sda_p & sda_f;

   // bit_cnt counts SCL rises within a byte; 8 means the byte is complete
   // and the next falling edge begins the ACK slot. PTR reuses 9 to mark
   // its own ACK slot since it has no dedicated ACK state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sda_oe   <= 1'b0;
         busy     <= 1'b0;
         wr_valid <= 1'b0;
         wr_reg   <= 8'h00;
         wr_data  <= 8'h00;
         rd_req   <= 1'b0;
         rd_reg   <= 8'h00;
         bit_cnt  <= 4'd0;
         shreg    <= 8'h00;
         ptr      <= 8'h00;
         rw       <= 1'b0;
         ack_bit  <= 1'b1;
         ld_cnt   <= 2'd0;
      end else begin
         wr_valid <= 1'b0;
         rd_req   <= 1'b0;
         if (start_det) begin
            state   <= ADDR;
            busy    <= 1'b1;
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
            ld_cnt  <= 2'd0;
         end else if (stop_det) begin
            state   <= IDLE;
            busy    <= 1'b0;
            sda_oe  <= 1'b0;
            bit_cnt <= 4'd0;
            ld_cnt  <= 2'd0;
         end else begin
            case (state)
               IDLE, IGNORE: ;
               ADDR: begin
                  if (scl_rise && bit_cnt < 4'd8) begin
                     shreg   <= {shreg[6:0], sda_f};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     bit_cnt <= 4'd0;
                     if (shreg[7:1] == ADDRESS) begin
                        state  <= ADDR_ACK;
                        sda_oe <= 1'b1;
                        rw     <= shreg[0];
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 4'd0;
                     if (rw) begin
                        state  <= RD_BYTE;
                        rd_req <= 1'b1;
                        rd_reg <= ptr;
                        ld_cnt <= 2'd2;
                     end else begin
                        state <= PTR;
                     end
                  end
               end
               PTR: begin
                  if (scl_rise && bit_cnt < 4'd8) begin
                     shreg   <= {shreg[6:0], sda_f};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     ptr     <= shreg;
                     sda_oe  <= 1'b1;
                     bit_cnt <= 4'd9;
                  end else if (scl_fall && bit_cnt == 4'd9) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 4'd0;
                     state   <= WR_BYTE;
                  end
               end
               WR_BYTE: begin
                  if (scl_rise && bit_cnt < 4'd8) begin
                     shreg   <= {shreg[6:0], sda_f};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     state    <= WR_ACK;
                     sda_oe   <= 1'b1;
                     wr_valid <= 1'b1;
                     wr_reg   <= ptr;
                     wr_data  <= shreg;
                     ptr      <= ptr + 8'd1;
                     bit_cnt  <= 4'd0;
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 4'd0;
                     state   <= WR_BYTE;
                  end
               end
               RD_BYTE: begin
                  // ld_cnt delays the latch so rd_data has two clks to settle.
                  if (ld_cnt != 2'd0) begin
                     ld_cnt <= ld_cnt - 2'd1;
                     if (ld_cnt == 2'd1) begin
                        shreg  <= rd_data;
                        sda_oe <= ~rd_data[7];
                        ptr    <= ptr + 8'd1;
                     end
                  end else if (scl_rise && bit_cnt < 4'd8) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        state   <= RD_ACK;
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                     end else if (bit_cnt != 4'd0) begin
                        shreg  <= {shreg[6:0], 1'b0};
                        sda_oe <= ~shreg[6];
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     ack_bit <= sda_f;
                  end else if (scl_fall) begin
                     bit_cnt <= 4'd0;
                     if (!ack_bit) begin
                        state  <= RD_BYTE;
                        rd_req <= 1'b1;
                        rd_reg <= ptr;
                        ld_cnt <= 2'd2;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'h42, 7-bit bus address the block responds to.
REQ-002 SHALL have parameter FILTER, default 3, number of consecutive equal clk samples needed to accept a new SCL/SDA level.
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port scl, input, 1 bit, bus clock from the controller.
REQ-006 SHALL have port sda, inout, 1 bit, open-drain data; the block drives only 1'b0 or 1'bz.
REQ-007 SHALL have port busy, output, 1 bit, high from an accepted START until the next STOP.
REQ-008 SHALL have port wr_valid, output, 1 bit, one-clk strobe qualifying wr_reg/wr_data.
REQ-009 SHALL have port wr_reg, output, 8 bits, register index of the write.
REQ-010 SHALL have port wr_data, output, 8 bits, written byte.
REQ-011 SHALL have port rd_req, output, 1 bit, one-clk strobe requesting rd_data for rd_reg.
REQ-012 SHALL have port rd_reg, output, 8 bits, register index being read.
REQ-013 SHALL have port rd_data, input, 8 bits, read byte; valid by the second clk after rd_req.

Function
REQ-014 SHALL pass scl and sda through a 2-flop synchronizer, then the FILTER-sample glitch filter; all decoding uses filtered levels only.
REQ-015 SHALL detect START as filtered SDA 1->0 while filtered SCL high, and STOP as SDA 0->1 while SCL high; a START in any state (repeated start) restarts at state ADDR.
REQ-016 SHALL sample SDA on filtered SCL rising edges, and change its own SDA drive only within 2 clks after filtered SCL falling edges.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-018 In ADDR, SHALL shift 8 bits MSB first; on address match go to ADDR_ACK, else go to IGNORE without driving SDA.
REQ-019 In ADDR_ACK, SHALL drive SDA low for the 9th SCL period, then go to PTR if R/W=0, or to RD_BYTE if R/W=1.
REQ-020 In PTR, SHALL receive 8 bits into the 8-bit register pointer, ACK, then go to WR_BYTE.
REQ-021 In WR_BYTE, SHALL receive 8 bits; during the following ACK, wr_valid SHALL pulse once with wr_reg=pointer and wr_data=byte; the pointer SHALL then increment modulo 256 (8'hFF wraps to 8'h00).
REQ-022 On entering RD_BYTE, rd_req SHALL pulse once with rd_reg=pointer; rd_data SHALL be latched 2 clks later and shifted out MSB first; the pointer SHALL increment modulo 256 after the latch.
REQ-023 In RD_ACK, SHALL release SDA and sample the controller ACK; on ACK (0) go to RD_BYTE for the next byte; on NACK (1) go to IGNORE.
REQ-024 IGNORE SHALL keep SDA released until STOP (-> IDLE) or START (-> ADDR).
REQ-025 A STOP in any state SHALL release SDA and go to IDLE; a STOP or START mid-byte SHALL discard the partial byte without wr_valid.
REQ-026 The pointer SHALL persist across transactions, including repeated START, and SHALL clear only on reset.
REQ-027 SHALL not stretch SCL (no clock stretching).

Reset
REQ-028 While rst is high: state IDLE, sda released (z), busy=0, wr_valid=0, rd_req=0, wr_reg=0, wr_data=0, rd_reg=0, and pointer=0, taking effect immediately even mid-transfer.
REQ-029 After rst deasserts, SHALL ignore the bus until a START is seen.

Verification
REQ-030 Write 0x84, 0x10, 0xAA, 0x55, STOP -> ACK on all 4 bytes; wr_valid (0x10,0xAA), then (0x11,0x55); busy 0 after STOP.
REQ-031 Write 0x84, 0x20, then repeated START 0x85, read 2 bytes (ACK, NACK) with rd_data=reg+1 -> rd_req for 0x20 and 0x21; bytes 0x21, 0x22 on SDA; SDA released after NACK.
REQ-032 Address 0x86 (0x43, write) -> no ACK, SDA never driven, no strobes, busy high until STOP.
REQ-033 Pointer 0xFF, write 2 bytes -> wr_reg 0xFF then 0x00.
REQ-034 1-clk SCL glitches during the data phase with FILTER=3 -> no extra bits or strobes; data identical to the glitch-free run.
REQ-035 Assert rst while block drives ACK low -> SDA z on the same cycle; all outputs 0; next valid transaction completes normally.
